// File: rtl/vgachargen_pkg.sv
// Shared geometry, widths, attribute/colour types and the CGA palette for the
// character-mode VGA pipeline.
package vgachargen_pkg;

    localparam int VGA_MAX_H_WIDTH = 10;
    localparam int VGA_MAX_V_WIDTH = 10;

    localparam int CH_W        = 8;
    localparam int CH_H        = 16;
    localparam int CH_COLS     = 80;
    localparam int CH_ROWS     = 30;
    localparam int CH_ADDR_W   = 12;
    localparam int FONT_ADDR_W = 12;

    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
    } attr_t;

    typedef logic [11:0] rgb_t;

    // Standard CGA 16-colour palette, {r,g,b} at 4 bits per channel
    localparam rgb_t PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/vga_blink_counter.sv
// Frame counter clocked by falling edges of vertical sync; its MSB is the
// blink phase (toggles every 16 frames).
module vga_blink_counter
    import vgachargen_pkg::*;
(
    input  logic clk_i,
    input  logic arstn_i,
    input  logic en_i,
    input  logic vs_i,
    output logic blink_phase_o
);

    logic       vs_prev_q;
    logic [4:0] cnt_q;
    logic       vs_fall;

    assign vs_fall       = vs_prev_q & ~vs_i;
    assign blink_phase_o = cnt_q[4];

    // Strobe-qualified vs edge detect and wrapping 5-bit frame count
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            vs_prev_q <= 1'b1;
            cnt_q     <= '0;
        end else if (en_i) begin
            vs_prev_q <= vs_i;
            if (vs_fall) cnt_q <= cnt_q + 5'd1;
        end
    end

endmodule

// File: rtl/vga_char_pixel_pipe.sv
// Character-mode pixel pipeline: text buffer fetch, font ROM fetch, colour
// lookup. Three pixel strobes from raster position to RGB, with syncs delayed
// by the same amount.
module vga_char_pixel_pipe
    import vgachargen_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       en_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hcount_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vcount_i,
    input  logic                       pixel_enable_i,
    input  logic                       vga_hs_i,
    input  logic                       vga_vs_i,
    output logic [CH_ADDR_W-1:0]       ch_addr_o,
    output logic                       ch_re_o,
    input  logic [7:0]                 ch_rdata_i,
    input  logic [7:0]                 attr_rdata_i,
    output logic [FONT_ADDR_W-1:0]     font_addr_o,
    output logic                       font_re_o,
    input  logic [7:0]                 font_rdata_i,
    output logic [3:0]                 vga_r_o,
    output logic [3:0]                 vga_g_o,
    output logic [3:0]                 vga_b_o,
    output logic                       vga_hs_o,
    output logic                       vga_vs_o
);

    // Stage registers; index = stage number
    logic [3:1] de_q, hs_q, vs_q;
    logic [2:0] x1_q, x2_q;
    logic [3:0] y1_q;
    attr_t      attr2_q;
    rgb_t       rgb_q;

    logic       blink_phase;
    logic [CH_ADDR_W+1:0] addr_full;
    logic       pix_bit;
    logic [3:0] idx;

    vga_blink_counter u_blink (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .en_i         (en_i),
        .vs_i         (vga_vs_i),
        .blink_phase_o(blink_phase)
    );

    // S0: text buffer address; computed wide, then truncated
    assign addr_full = (CH_ADDR_W+2)'(vcount_i[VGA_MAX_V_WIDTH-1:4]) * (CH_ADDR_W+2)'(CH_COLS)
                     + (CH_ADDR_W+2)'(hcount_i[VGA_MAX_H_WIDTH-1:3]);
    assign ch_addr_o = addr_full[CH_ADDR_W-1:0];
    assign ch_re_o   = en_i;

    // S1: glyph row address from the fetched code
    assign font_addr_o = {ch_rdata_i, y1_q};
    assign font_re_o   = en_i;

    // S2: pick glyph bit, apply blink, select colour index
    always_comb begin
        pix_bit = font_rdata_i[3'd7 - x2_q];
        if (attr2_q.blink && blink_phase) pix_bit = 1'b0;
        idx = pix_bit ? attr2_q.fg : {1'b0, attr2_q.bg};
    end

    // Pipeline advance, held entirely while the pixel strobe is low
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            de_q    <= '0;
            hs_q    <= '1;
            vs_q    <= '1;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            attr2_q <= '0;
            rgb_q   <= '0;
        end else if (en_i) begin
            de_q    <= {de_q[2:1], pixel_enable_i};
            hs_q    <= {hs_q[2:1], vga_hs_i};
            vs_q    <= {vs_q[2:1], vga_vs_i};
            x1_q    <= hcount_i[2:0];
            y1_q    <= vcount_i[3:0];
            x2_q    <= x1_q;
            attr2_q <= attr_t'(attr_rdata_i);
            rgb_q   <= de_q[2] ? PALETTE[idx] : 12'h000;
        end
    end

    assign {vga_r_o, vga_g_o, vga_b_o} = rgb_q;
    assign vga_hs_o = hs_q[3];
    assign vga_vs_o = vs_q[3];

endmodule

// File: tb/tb_vga_char_pixel_pipe.sv
// Directed bench for the character pixel pipeline with behavioural text
// buffer and font ROM models.
module tb_vga_char_pixel_pipe;
    import vgachargen_pkg::*;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        en_i = 1'b0;
    logic [9:0]  hcount_i = '0;
    logic [9:0]  vcount_i = '0;
    logic        pixel_enable_i = 1'b0;
    logic        vga_hs_i = 1'b1;
    logic        vga_vs_i = 1'b1;
    logic [11:0] ch_addr_o;
    logic        ch_re_o;
    logic [7:0]  ch_rdata_i = '0;
    logic [7:0]  attr_rdata_i = '0;
    logic [11:0] font_addr_o;
    logic        font_re_o;
    logic [7:0]  font_rdata_i = '0;
    logic [3:0]  vga_r_o, vga_g_o, vga_b_o;
    logic        vga_hs_o, vga_vs_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] tmem [4096];
    logic [7:0] amem [4096];
    logic [7:0] fmem [4096];

    vga_char_pixel_pipe dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .en_i(en_i),
        .hcount_i(hcount_i), .vcount_i(vcount_i), .pixel_enable_i(pixel_enable_i),
        .vga_hs_i(vga_hs_i), .vga_vs_i(vga_vs_i),
        .ch_addr_o(ch_addr_o), .ch_re_o(ch_re_o),
        .ch_rdata_i(ch_rdata_i), .attr_rdata_i(attr_rdata_i),
        .font_addr_o(font_addr_o), .font_re_o(font_re_o), .font_rdata_i(font_rdata_i),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
        .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read memories: data one clk after an enabled edge, else held
    always @(posedge clk_i) begin
        if (ch_re_o) begin
            ch_rdata_i   <= tmem[ch_addr_o];
            attr_rdata_i <= amem[ch_addr_o];
        end
        if (font_re_o) font_rdata_i <= fmem[font_addr_o];
    end

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        de, hs, vs;
        logic [11:0] rgb;
        logic        ehs, evs;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [11:0] rgb_out();
        return {vga_r_o, vga_g_o, vga_b_o};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v,
                         input logic de, input logic hs, input logic vs);
        hcount_i = h; vcount_i = v; pixel_enable_i = de; vga_hs_i = hs; vga_vs_i = vs;
    endtask

    task automatic step(input logic [9:0] h, input logic [9:0] v,
                        input logic de, input logic hs, input logic vs);
        drive(h, v, de, hs, vs);
        en_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic idle_step();
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        en_i = 1'b0;
        arstn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 arstn_i = 1'b1;
    endtask

    task automatic chk_vec(input int i, input string tag);
        chk($sformatf("%s_rgb%0d", tag, i), rgb_out(), tbl[i].rgb);
        chk($sformatf("%s_hs%0d", tag, i), {11'd0, vga_hs_o}, {11'd0, tbl[i].ehs});
        chk($sformatf("%s_vs%0d", tag, i), {11'd0, vga_vs_o}, {11'd0, tbl[i].evs});
    endtask

    initial begin
        logic [11:0] snap;
        logic        snap_hs, snap_vs;

        for (int a = 0; a < 4096; a++) begin
            tmem[a] = 8'h00; amem[a] = 8'h00; fmem[a] = 8'h00;
        end
        tmem[162]  = 8'h41; amem[162]  = 8'h1F; fmem[12'h413] = 8'b0010_0000;
        tmem[0]    = 8'h02; amem[0]    = 8'h4E; fmem[12'h020] = 8'h80;
        tmem[2399] = 8'hFF; amem[2399] = 8'h29; fmem[12'hFFF] = 8'h01;
        tmem[2]    = 8'h03; amem[2]    = 8'h87; fmem[12'h030] = 8'hFF;

        //            h    v    de  hs  vs   rgb      hs  vs
        tbl[0] = '{10'd17,  10'd35,  1, 1, 1, 12'h00A, 1, 1};
        tbl[1] = '{10'd18,  10'd35,  1, 1, 1, 12'hFFF, 1, 1};
        tbl[2] = '{10'd17,  10'd35,  0, 1, 1, 12'h000, 1, 1};
        tbl[3] = '{10'd700, 10'd35,  0, 0, 1, 12'h000, 0, 1};
        tbl[4] = '{10'd0,   10'd0,   1, 1, 1, 12'hFF5, 1, 1};
        tbl[5] = '{10'd1,   10'd0,   1, 1, 1, 12'hA00, 1, 1};
        tbl[6] = '{10'd639, 10'd479, 1, 1, 1, 12'h55F, 1, 1};
        tbl[7] = '{10'd638, 10'd479, 1, 1, 1, 12'h0A0, 1, 1};
        tbl[8] = '{10'd640, 10'd479, 0, 1, 1, 12'h000, 1, 1};
        tbl[9] = '{10'd700, 10'd490, 0, 1, 0, 12'h000, 1, 0};

        do_reset();
        chk("reset_rgb", rgb_out(), 12'h000);
        chk("reset_hs", {11'd0, vga_hs_o}, 12'd1);
        chk("reset_vs", {11'd0, vga_vs_o}, 12'd1);

        // Address and font address of the first glyph fetch
        drive(10'd17, 10'd35, 1'b1, 1'b1, 1'b1);
        #1 chk("ch_addr", ch_addr_o, 12'd162);
        chk("ch_re", {11'd0, ch_re_o}, 12'd0);
        en_i = 1'b1;
        #1 chk("ch_re_on", {11'd0, ch_re_o}, 12'd1);
        @(posedge clk_i); #1;
        chk("font_addr", font_addr_o, 12'h413);
        drive(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
        #1 chk("ch_addr_last", ch_addr_o, 12'd2399);
        repeat (3) idle_step();

        // Back-to-back strobes: output for vector i visible after strobe i+2
        for (int i = 0; i < 12; i++) begin
            if (i < 10) step(tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].hs, tbl[i].vs);
            else        idle_step();
            if (i >= 2) chk_vec(i - 2, "b2b");
        end

        // Same vectors with gapped strobes; outputs must hold across gaps
        for (int i = 0; i < 12; i++) begin
            if (i < 10) step(tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].hs, tbl[i].vs);
            else        idle_step();
            en_i = 1'b0;
            if (i >= 2) chk_vec(i - 2, "stall");
            snap = rgb_out(); snap_hs = vga_hs_o; snap_vs = vga_vs_o;
            drive(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
                  1'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(1, 4)) begin
                @(posedge clk_i); #1;
                chk("stall_hold_rgb", rgb_out(), snap);
                chk("stall_hold_sync", {10'd0, vga_hs_o, vga_vs_o}, {10'd0, snap_hs, snap_vs});
            end
        end

        // Blink: 33 frames, blinking fg 7 over bg 0 with a solid glyph row
        do_reset();
        for (int f = 0; f <= 32; f++) begin
            step(10'd16, 10'd0, 1'b1, 1'b1, 1'b1);
            idle_step();
            idle_step();
            chk($sformatf("blink_f%0d", f), rgb_out(), (f < 16 || f >= 32) ? 12'hAAA : 12'h000);
            step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
            idle_step();
        end
        chk("blink_cnt", {7'd0, dut.u_blink.cnt_q}, 12'd1);

        // Reset mid-line with a lit pixel on the output
        for (int k = 0; k < 3; k++) step(10'd18, 10'd35, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_rgb", rgb_out(), 12'hFFF);
        arstn_i = 1'b0;
        #1;
        chk("rst_rgb", rgb_out(), 12'h000);
        chk("rst_sync", {10'd0, vga_hs_o, vga_vs_o}, 12'd3);
        chk("rst_cnt", {7'd0, dut.u_blink.cnt_q}, 12'd0);
        @(posedge clk_i); #1 arstn_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(10'd18, 10'd35, 1'b1, 1'b1, 1'b1);
            chk($sformatf("refill%0d_rgb", k), rgb_out(), (k == 3) ? 12'hFFF : 12'h000);
            chk($sformatf("refill%0d_sync", k), {10'd0, vga_hs_o, vga_vs_o}, 12'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
